// File: rtl/urng_taus_u0.sv
// urng_taus_u0: uniform random number source for the AWGN datapath.
//
// Two independent combined Tausworthe (taus88) generators, A and B.
// Each enabled cycle produces a 48-bit uniform u0 = {a0, a1[31:16]} and a
// 16-bit uniform u1 = a1[15:0]. Here a0 is the output of A and a1 is the
// output of B. exp_e is the normalisation shift for u0: the leading-zero
// count of u0 plus 1, so the range is 1..49.
//
// Optional feature macro: AWGN_EXP_E_EN.
//   - Defined:   exp_e is computed and registered alongside u0.
//   - Undefined: exp_e is tied to 0 and no leading-zero logic is built.
//
// Ports:
//   clk        in   1    system clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   seed_load  in   1    load the sanitised seed into the generator state
//   seed       in   192  {B.s3, B.s2, B.s1, A.s3, A.s2, A.s1}, 32 b each
//   en         in   1    advance the generators and produce a sample
//   u0         out  48   {a0[31:0], a1[31:16]}
//   u1         out  16   a1[15:0]
//   exp_e      out  6    lzc(u0) + 1 (0 when AWGN_EXP_E_EN is undefined)
//   valid      out  1    u0/u1/exp_e hold a fresh sample this cycle
//   seed_err   out  1    the last load contained an illegal component
module urng_taus_u0 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         seed_load,
    input  logic [191:0] seed,
    input  logic         en,
    output logic [47:0]  u0,
    output logic [15:0]  u1,
    output logic [5:0]   exp_e,
    output logic         valid,
    output logic         seed_err
);

    // Generator state is packed as {s3, s2, s1}.
    localparam logic [95:0] A_DEF = {32'hBB67AE85, 32'h6C078965, 32'hA3C59AC3};
    localparam logic [95:0] B_DEF = {32'h510E527F, 32'hA54FF53A, 32'h3C6EF372};

    function automatic logic [95:0] taus_step(input logic [95:0] s);
        logic [31:0] s1, s2, s3, b1, b2, b3, n1, n2, n3;
        s1 = s[31:0];
        s2 = s[63:32];
        s3 = s[95:64];
        b1 = ((s1 << 13) ^ s1) >> 19;
        n1 = ((s1 & 32'hFFFFFFFE) << 12) ^ b1;
        b2 = ((s2 << 2) ^ s2) >> 25;
        n2 = ((s2 & 32'hFFFFFFF8) << 4) ^ b2;
        b3 = ((s3 << 3) ^ s3) >> 11;
        n3 = ((s3 & 32'hFFFFFFF0) << 17) ^ b3;
        return {n3, n2, n1};
    endfunction

    // Per-component legality: s1 >= 2, s2 >= 8, s3 >= 16.
    // Each bit tests for any set bit above the illegal range.
    function automatic logic [2:0] legal_mask(input logic [95:0] s);
        return {|s[95:68], |s[63:35], |s[31:1]};
    endfunction

    function automatic logic [95:0] sanitize(input logic [95:0] s, input logic [95:0] def);
        logic [2:0] ok;
        ok = legal_mask(s);
        return {ok[2] ? s[95:64] : def[95:64],
                ok[1] ? s[63:32] : def[63:32],
                ok[0] ? s[31:0]  : def[31:0]};
    endfunction

    logic [95:0] a_q, a_d, b_q, b_d;
    logic [95:0] a_nxt, b_nxt;
    logic [31:0] a_out, b_out;
    logic [47:0] u0_q, u0_d, u0_nxt;
    logic [15:0] u1_q, u1_d;
    logic        valid_q, valid_d;
    logic        seed_err_q, seed_err_d;

    always_comb begin
        a_nxt  = taus_step(a_q);
        b_nxt  = taus_step(b_q);
        a_out  = a_nxt[31:0] ^ a_nxt[63:32] ^ a_nxt[95:64];
        b_out  = b_nxt[31:0] ^ b_nxt[63:32] ^ b_nxt[95:64];
        u0_nxt = {a_out, b_out[31:16]};

        a_d        = a_q;
        b_d        = b_q;
        u0_d       = u0_q;
        u1_d       = u1_q;
        valid_d    = 1'b0;
        seed_err_d = seed_err_q;

        if (seed_load) begin
            a_d        = sanitize(seed[95:0], A_DEF);
            b_d        = sanitize(seed[191:96], B_DEF);
            seed_err_d = ~&{legal_mask(seed[95:0]), legal_mask(seed[191:96])};
        end else if (en) begin
            a_d     = a_nxt;
            b_d     = b_nxt;
            u0_d    = u0_nxt;
            u1_d    = b_out[15:0];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= A_DEF;
            b_q        <= B_DEF;
            u0_q       <= '0;
            u1_q       <= '0;
            valid_q    <= 1'b0;
            seed_err_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            u0_q       <= u0_d;
            u1_q       <= u1_d;
            valid_q    <= valid_d;
            seed_err_q <= seed_err_d;
        end
    end

`ifdef AWGN_EXP_E_EN
    logic [5:0] exp_e_q, exp_e_d, lz_exp;

    // Scan upward so the highest set bit wins; all-zero u0 gives 49.
    always_comb begin
        lz_exp = 6'd49;
        for (int unsigned i = 0; i < 48; i++) begin
            if (u0_nxt[i]) begin
                lz_exp = 6'(48 - i);
            end
        end
        exp_e_d = exp_e_q;
        if (!seed_load && en) begin
            exp_e_d = lz_exp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_e_q <= '0;
        end else begin
            exp_e_q <= exp_e_d;
        end
    end

    assign exp_e = exp_e_q;
`else
    assign exp_e = '0;
`endif

    assign u0       = u0_q;
    assign u1       = u1_q;
    assign valid    = valid_q;
    assign seed_err = seed_err_q;

endmodule

// File: tb/tb_urng_taus_u0.sv
module tb_urng_taus_u0;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         seed_load;
    logic [191:0] seed;
    logic         en;
    logic [47:0]  u0;
    logic [15:0]  u1;
    logic [5:0]   exp_e;
    logic         valid;
    logic         seed_err;

    int n_checks = 0;
    int n_errors = 0;

    urng_taus_u0 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .en        (en),
        .u0        (u0),
        .u1        (u1),
        .exp_e     (exp_e),
        .valid     (valid),
        .seed_err  (seed_err)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] A1D = 32'hA3C59AC3, A2D = 32'h6C078965, A3D = 32'hBB67AE85;
    localparam logic [31:0] B1D = 32'h3C6EF372, B2D = 32'hA54FF53A, B3D = 32'h510E527F;

    // Reference taus88 model state
    logic [31:0] ma1, ma2, ma3, mb1, mb2, mb3;
    logic [47:0] m_u0;
    logic [15:0] m_u1;

    function automatic logic [191:0] mk_seed(input logic [31:0] a1, a2, a3, b1, b2, b3);
        return {b3, b2, b1, a3, a2, a1};
    endfunction

    function automatic logic [5:0] exp_ref(input logic [47:0] v);
`ifdef AWGN_EXP_E_EN
        for (int i = 47; i >= 0; i--) begin
            if (v[i]) return 6'(48 - i);
        end
        return 6'd49;
`else
        return 6'd0;
`endif
    endfunction

    // One taus88 step on a triple, returns the combined output word.
    task automatic taus(inout logic [31:0] s1, inout logic [31:0] s2,
                        inout logic [31:0] s3, output logic [31:0] o);
        logic [31:0] t;
        t  = (s1 << 13) ^ s1;
        s1 = ((s1 & 32'hFFFFFFFE) << 12) ^ (t >> 19);
        t  = (s2 << 2) ^ s2;
        s2 = ((s2 & 32'hFFFFFFF8) << 4) ^ (t >> 25);
        t  = (s3 << 3) ^ s3;
        s3 = ((s3 & 32'hFFFFFFF0) << 17) ^ (t >> 11);
        o  = s1 ^ s2 ^ s3;
    endtask

    task automatic model_adv();
        logic [31:0] oa, ob;
        taus(ma1, ma2, ma3, oa);
        taus(mb1, mb2, mb3, ob);
        m_u0 = {oa, ob[31:16]};
        m_u1 = ob[15:0];
    endtask

    task automatic model_defaults();
        ma1 = A1D; ma2 = A2D; ma3 = A3D;
        mb1 = B1D; mb2 = B2D; mb3 = B3D;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_sample(input string tag, input logic [47:0] eu0, input logic [15:0] eu1,
                                input logic ev);
        check({tag, "_u0"}, 64'(u0), 64'(eu0));
        check({tag, "_u1"}, 64'(u1), 64'(eu1));
        check({tag, "_exp"}, 64'(exp_e), 64'(exp_ref(eu0)));
        check({tag, "_valid"}, 64'(valid), 64'(ev));
    endtask

    // Apply current inputs across one rising edge, then settle for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string        name;
        logic         ld;
        logic [191:0] sd;
        logic         en;
        logic [47:0]  u0;
        logic [15:0]  u1;
        logic         v;
        logic         err;
    } vec_t;

    vec_t tbl[8];

    localparam logic [47:0] KA_U0 = 48'h0020_2080_0020;
    localparam logic [15:0] KA_U1 = 16'h2080;
    localparam logic [47:0] K2_U0 = 48'h0020_2080_0040;
    localparam logic [15:0] K2_U1 = 16'h4100;
`ifdef AWGN_EXP_E_EN
    localparam logic [5:0] KA_EXP = 6'd11;
`else
    localparam logic [5:0] KA_EXP = 6'd0;
`endif

    initial begin
        logic [191:0] s_ka, s_k2;
        s_ka = mk_seed(2, 8, 16, 2, 8, 16);
        s_k2 = mk_seed(2, 8, 16, 4, 16, 32);

        tbl[0] = '{"ka_load",   1'b1, s_ka, 1'b0, 48'h0, 16'h0, 1'b0, 1'b0};
        tbl[1] = '{"ka_sample", 1'b0, '0,   1'b1, KA_U0, KA_U1, 1'b1, 1'b0};
        tbl[2] = '{"idle_hold", 1'b0, '0,   1'b0, KA_U0, KA_U1, 1'b0, 1'b0};
        tbl[3] = '{"load_en",   1'b1, s_k2, 1'b1, KA_U0, KA_U1, 1'b0, 1'b0};
        tbl[4] = '{"k2_sample", 1'b0, '0,   1'b1, K2_U0, K2_U1, 1'b1, 1'b0};
        tbl[5] = '{"bad_s3",    1'b1, mk_seed(2, 8, 16, 2, 8, 15), 1'b0, K2_U0, K2_U1, 1'b0, 1'b1};
        tbl[6] = '{"err_hold",  1'b0, '0,   1'b0, K2_U0, K2_U1, 1'b0, 1'b1};
        tbl[7] = '{"err_clear", 1'b1, s_ka, 1'b0, K2_U0, K2_U1, 1'b0, 1'b0};

        rst_n = 1'b0; seed_load = 1'b0; seed = '0; en = 1'b0;
        #1;
        check_sample("rst", '0, '0, 1'b0);
        check("rst_err", 64'(seed_err), 64'(0));
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_sample("idle", '0, '0, 1'b0);
        end

        // Table-driven known-answer vectors
        for (int i = 0; i < 8; i++) begin
            seed_load = tbl[i].ld; seed = tbl[i].sd; en = tbl[i].en;
            step();
            check_sample(tbl[i].name, tbl[i].u0, tbl[i].u1, tbl[i].v);
            check({tbl[i].name, "_err"}, 64'(seed_err), 64'(tbl[i].err));
        end
        seed_load = 1'b0; en = 1'b1;
        step();
        check("ka_exp_explicit", 64'(exp_e), 64'(KA_EXP));
        check_sample("ka_again", KA_U0, KA_U1, 1'b1);

        // Illegal A.s1 = 1 falls back to its default
        seed_load = 1'b1; en = 1'b0; seed = mk_seed(1, 8, 16, 2, 8, 16);
        step();
        check("bad_s1_err", 64'(seed_err), 64'(1));
        check("bad_s1_valid", 64'(valid), 64'(0));
        ma1 = A1D; ma2 = 8; ma3 = 16; mb1 = 2; mb2 = 8; mb3 = 16;
        seed_load = 1'b0; en = 1'b1;
        step();
        model_adv();
        check_sample("bad_s1_smp", m_u0, m_u1, 1'b1);
        check("bad_s1_err_hold", 64'(seed_err), 64'(1));

        // Illegal A.s2 = 7 with B legal and large
        seed_load = 1'b1; en = 1'b0; seed = mk_seed(2, 7, 16, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F);
        step();
        check("bad_s2_err", 64'(seed_err), 64'(1));
        ma1 = 2; ma2 = A2D; ma3 = 16; mb1 = 32'h12345678; mb2 = 32'h9ABCDEF0; mb3 = 32'h0F0F0F0F;
        seed_load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            model_adv();
            check_sample("bad_s2_smp", m_u0, m_u1, 1'b1);
        end

        // All-zero seed: every component replaced by its default
        seed_load = 1'b1; en = 1'b1; seed = '0;
        step();
        check("zero_err", 64'(seed_err), 64'(1));
        check_sample("zero_hold", m_u0, m_u1, 1'b0);
        model_defaults();
        seed_load = 1'b0;
        step();
        model_adv();
        check_sample("zero_smp", m_u0, m_u1, 1'b1);

        // Reset asserted mid-stream clears outputs immediately
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_sample("midrst", '0, '0, 1'b0);
        check("midrst_err", 64'(seed_err), 64'(0));
        step();
        rst_n = 1'b1;
        model_defaults();

        // Long stream from the defaults
        en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            step();
            model_adv();
            check_sample("stream", m_u0, m_u1, 1'b1);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_sample("pause", m_u0, m_u1, 1'b0);
        end
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            model_adv();
            check_sample("resume", m_u0, m_u1, 1'b1);
        end
        en = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
